// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction-fetch front end (fetch PC, imem request/response, prefetch FIFO).
// Latency: request accepted in cycle N, response in N+k, instruction at the FIFO head in N+k+1.
// Backpressure: requests are credit-limited (FIFO occupancy + in-flight <= FIFO_DEPTH); decode stalls via inst_ready.
// Ports: clk, reset (async, active-high)
//        imem_req_valid/ready/addr : fetch request, addr = fetch PC
//        imem_rsp_valid/data       : in-order response, always accepted
//        redirect_valid/pc         : branch/jump taken, flush and refetch from redirect_pc
//        inst_valid/ready, inst, inst_pc : FIFO head towards decode
//        fifo_count                : current FIFO occupancy

// Prefetch FIFO: flushable, head shown combinationally, full/empty derived from count.
module fetch_unit_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              PC_STEP    = 4,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [ILEN-1:0]               imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [ILEN-1:0]               inst,
  output logic [XLEN-1:0]               inst_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int              CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0]      fetch_pc;
  logic [XLEN-1:0]      rsp_pc;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        discard;
  logic [CW:0]          credits_used;
  logic                 req_fire;
  logic                 rsp_keep;
  logic                 fifo_pop;
  logic [ILEN+XLEN-1:0] head_dat;

  // Every in-flight request owns a FIFO slot, so the FIFO can never overflow.
  assign credits_used   = {1'b0, fifo_count} + {1'b0, inflight};
  assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses to requests issued before a redirect are stale and must not reach decode.
  assign rsp_keep = imem_rsp_valid && (discard == '0) && !redirect_valid;

  assign inst_valid = (fifo_count != '0);
  assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;
  assign inst       = inst_valid ? head_dat[ILEN+XLEN-1:XLEN] : '0;
  assign inst_pc    = inst_valid ? head_dat[XLEN-1:0]         : '0;

  fetch_unit_fifo #(
    .WIDTH (ILEN + XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (rsp_keep),
    .push_dat ({imem_rsp_data, rsp_pc}),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      // No request issues in a redirect cycle. Everything still outstanding after this
      // cycle's response is stale; discards still pending from an earlier redirect are
      // already part of inflight, so they are carried along without double counting.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      inflight <= inflight - CW'(imem_rsp_valid);
      discard  <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + STEP;
      if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: byte-addressed instance (RESET_PC=0x100, step 4) and word-mode instance (step 1).
// Memory models respond in order after a programmable latency; a scoreboard checks every popped instruction.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // byte-addressed instance
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  // word-mode instance
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_inst_valid;
  logic        w_inst_ready = 1'b1;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic [2:0]  w_fifo_count;

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h100), .PC_STEP(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fifo_count(fifo_count)
  );

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .PC_STEP(1), .FIFO_DEPTH(4)) u_word (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
    .fifo_count(w_fifo_count)
  );

  typedef struct packed { logic [31:0] addr; int due; } pend_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] dat; } exp_t;

  pend_t pend_q[$];
  pend_t w_pend_q[$];
  exp_t  exp_q[$];
  exp_t  w_exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int outstanding = 0;
  int w_outstanding = 0;
  int req_count = 0;
  int pop_cnt = 0;
  int w_pop_cnt = 0;
  int max_cnt = 0;
  int w_max_cnt = 0;
  int hs_cyc = -1;
  int iv_cyc = -100;
  logic [31:0] exp_fetch_pc = 32'h100;
  logic [31:0] w_exp_pc = 32'h0;
  logic [31:0] w_held = '0;
  bit w_stalled = 1'b0;
  bit w_active = 1'b0;
  bit found = 1'b0;
  exp_t e;
  exp_t we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic push_main(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc, memf(pc)});
      pc = pc + 32'd4;
    end
  endtask

  task automatic wait_pops(input int n, input string name);
    int target;
    int k;
    target = pop_cnt + n;
    k = 0;
    while (pop_cnt < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(pop_cnt >= target), 32'd1);
  endtask

  // Redirect for one cycle; 'last' releases it and checks the cycle after.
  task automatic do_redirect(input logic [31:0] t, input bit last);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    exp_q.delete();
    exp_fetch_pc   = t;
    push_main(t, 48);
    @(negedge clk);
    chk("redir_req_valid_low", 32'(req_valid), 32'd0);
    @(posedge clk);
    #1;
    if (last) begin
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_fifo_count", 32'(fifo_count), 32'd0);
      chk("redir_inst_valid", 32'(inst_valid), 32'd0);
      chk("redir_first_valid", 32'(req_valid), 32'd1);
      chk("redir_first_addr", req_addr, t);
    end
  endtask

  // Memory models: drive in-order responses shortly after the clock edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = memf(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    if (w_pend_q.size() > 0 && w_pend_q[0].due <= cyc) begin
      w_rsp_valid = 1'b1;
      w_rsp_data  = memf(w_pend_q[0].addr);
      void'(w_pend_q.pop_front());
    end else begin
      w_rsp_valid = 1'b0;
      w_rsp_data  = '0;
    end
  end

  // Request acceptance and scoreboard monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        assert (outstanding > 0) else $error("FAIL protocol: response with no request in flight");
        outstanding--;
      end
      if (req_valid && req_ready) begin
        chk("req_addr", req_addr, exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        pend_q.push_back('{req_addr, cyc + mem_lat});
        outstanding++;
        req_count++;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inst_unexpected: got pc 0x%h, scoreboard empty", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", inst, e.dat);
        end
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);

      if (w_rsp_valid) begin
        assert (w_outstanding > 0) else $error("FAIL w_protocol: response with no request in flight");
        w_outstanding--;
      end
      if (w_active && w_stalled && w_req_valid) chk("w_addr_stable", w_req_addr, w_held);
      w_stalled = w_req_valid && !w_req_ready;
      w_held    = w_req_addr;
      if (w_req_valid && w_req_ready) begin
        chk("w_req_addr", w_req_addr, w_exp_pc);
        w_exp_pc = w_exp_pc + 32'd1;
        w_pend_q.push_back('{w_req_addr, cyc + 1});
        w_outstanding++;
      end
      if (w_inst_valid && w_inst_ready) begin
        w_pop_cnt++;
        if (w_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w_inst_unexpected: got pc 0x%h, scoreboard empty", w_inst_pc);
        end else begin
          we = w_exp_q.pop_front();
          chk("w_inst_pc", w_inst_pc, we.pc);
          chk("w_inst", w_inst, we.dat);
        end
      end
      if (int'(w_fifo_count) > w_max_cnt) w_max_cnt = int'(w_fifo_count);
    end
  end

  logic [15:0] w_pat;

  initial begin
    reset          = 1'b1;
    req_ready      = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    w_req_ready    = 1'b0;
    push_main(32'h100, 48);
    for (int i = 0; i < 24; i++) w_exp_q.push_back('{32'(i), memf(32'(i))});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_w_req_valid", 32'(w_req_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First-instruction latency with decode stalled, then backpressure
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hs_cyc < 0 && req_valid && req_ready) hs_cyc = cyc;
      if (inst_valid) begin
        iv_cyc = cyc;
        break;
      end
    end
    chk("first_inst_latency", 32'(iv_cyc - hs_cyc), 32'd2);
    repeat (10) @(negedge clk);
    chk("bp_req_count", 32'(req_count), 32'd4);
    chk("bp_fifo_count", 32'(fifo_count), 32'd4);
    chk("bp_req_valid", 32'(req_valid), 32'd0);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    wait_pops(12, "stream_pops");

    // Redirect with several requests in flight (3-cycle memory)
    @(posedge clk);
    #1;
    mem_lat = 3;
    repeat (8) @(posedge clk);
    #1;
    do_redirect(32'h2000, 1'b1);
    wait_pops(6, "redir_pops");

    // Redirect coinciding with a response and a pop (1-cycle memory)
    @(posedge clk);
    #1;
    mem_lat = 1;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (rsp_valid && inst_valid && inst_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("coincide_found", 32'(found), 32'd1);
    do_redirect(32'h3000, 1'b1);
    wait_pops(6, "coincide_pops");

    // Back-to-back redirects: the second target wins
    @(posedge clk);
    #1;
    mem_lat = 3;
    repeat (8) @(posedge clk);
    #1;
    do_redirect(32'h4000, 1'b0);
    do_redirect(32'h5000, 1'b1);
    wait_pops(6, "b2b_pops");

    // Address wrap at the top of the address space
    @(posedge clk);
    #1;
    mem_lat = 1;
    repeat (4) @(posedge clk);
    #1;
    do_redirect(32'hFFFF_FFFC, 1'b1);
    wait_pops(4, "wrap_pops");

    // Word mode with a stalling request channel
    w_active = 1'b1;
    w_pat    = 16'b1111_1011_1010_0110;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      w_req_ready = w_pat[i];
    end
    @(posedge clk);
    #1;
    w_req_ready = 1'b1;
    for (int k = 0; k < 100 && w_pop_cnt < 8; k++) @(negedge clk);
    chk("w_pops", 32'(w_pop_cnt >= 8), 32'd1);

    chk("max_fifo_count", 32'(max_cnt), 32'd4);
    chk("w_max_fifo_count", 32'(w_max_cnt <= 4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
